// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, stall causes
// and the default multiply/divide latency.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    typedef enum logic [2:0] {
        CauseNone,
        CauseMem,
        CauseLoadUse,
        CauseMdu,
        CauseBranch,
        CauseFetch
    } cause_e;

    localparam int unsigned MduLatDefault = 32;
    localparam int unsigned MduCntW       = 6;

endpackage

// File: rtl/mdu_tracker.sv
// Multiply/divide result tracker: counts down from MDU_LAT after an accepted
// issue and reports busy until HI/LO are valid.
module mdu_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MduLatDefault
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    output logic busy_o
);

    localparam logic [MduCntW-1:0] LatLoad = MduCntW'(MDU_LAT);

    logic [MduCntW-1:0] cnt_q, cnt_d;

    // A new issue always reloads, even while a previous result is pending.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = LatLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MduCntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Optional stall
// performance counter enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MduLatDefault,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             mdu_start_i,
    input  logic             id_mdu_read_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             mdu_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_e state_q, state_d;
    cause_e cause;
    logic   mem_freeze, load_use, mdu_hazard, mdu_start_ok;

    assign mem_freeze = dmem_req_i & ~dmem_ready_i;
    assign load_use   = idex_memread_i && (idex_rt_i != 5'd0) &&
                        ((idex_rt_i == ifid_rs_i) || (id_uses_rt_i && (idex_rt_i == ifid_rt_i)));
    assign mdu_hazard = id_mdu_read_i & mdu_busy_o;

    always_comb begin
        cause = CauseNone;
        if (reset_i) begin
            cause = CauseNone;
        end else if (mem_freeze) begin
            cause = CauseMem;
        end else if (load_use) begin
            cause = CauseLoadUse;
        end else if (mdu_hazard) begin
            cause = CauseMdu;
        end else if (branch_taken_i) begin
            cause = CauseBranch;
        end else if (!imem_ready_i) begin
            cause = CauseFetch;
        end
    end

    always_comb begin
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_en_o    = 1'b1;
        memwb_en_o    = 1'b1;
        if (reset_i) begin
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_en_o    = 1'b0;
            memwb_en_o    = 1'b0;
        end else begin
            unique case (cause)
                CauseMem: begin
                    pc_en_o    = 1'b0;
                    ifid_en_o  = 1'b0;
                    exmem_en_o = 1'b0;
                    memwb_en_o = 1'b0;
                end
                CauseLoadUse, CauseMdu: begin
                    pc_en_o       = 1'b0;
                    ifid_en_o     = 1'b0;
                    idex_bubble_o = 1'b1;
                end
                CauseBranch: ifid_flush_o = 1'b1;
                // IF/ID still loads, but with a NOP while the fetch is outstanding.
                CauseFetch: begin
                    pc_en_o      = 1'b0;
                    ifid_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (mem_freeze) state_d = StMemWait;
            StMemWait: if (dmem_ready_i) state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // An issue is only real when the EX instruction actually advances.
    assign mdu_start_ok = mdu_start_i & exmem_en_o;

    mdu_tracker #(
        .MDU_LAT(MDU_LAT)
    ) u_mdu (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(mdu_start_ok),
        .busy_o (mdu_busy_o)
    );

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a cycle-indexed reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_pipeline_stall_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 4;
    localparam int          CntMax = (1 << CW) - 1;
`ifdef STALL_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic          clk, reset;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          id_uses_rt, idex_memread, branch_taken, imem_ready;
    logic          dmem_req, dmem_ready, mdu_start, id_mdu_read;
    logic          pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, mdu_busy;
    logic [CW-1:0] stall_cnt;

    pipeline_stall_ctrl #(
        .MDU_LAT(LAT),
        .CNT_W  (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ifid_rs_i     (ifid_rs),
        .ifid_rt_i     (ifid_rt),
        .id_uses_rt_i  (id_uses_rt),
        .idex_rt_i     (idex_rt),
        .idex_memread_i(idex_memread),
        .branch_taken_i(branch_taken),
        .imem_ready_i  (imem_ready),
        .dmem_req_i    (dmem_req),
        .dmem_ready_i  (dmem_ready),
        .mdu_start_i   (mdu_start),
        .id_mdu_read_i (id_mdu_read),
        .pc_en_o       (pc_en),
        .ifid_en_o     (ifid_en),
        .ifid_flush_o  (ifid_flush),
        .idex_bubble_o (idex_bubble),
        .exmem_en_o    (exmem_en),
        .memwb_en_o    (memwb_en),
        .mdu_busy_o    (mdu_busy),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference state: cycle index, cycle of the last accepted MDU issue,
    // memory-wait flag and the stall-cycle tally.
    int cyc        = 0;
    int last_start = -1000;
    bit m_wait     = 1'b0;
    int m_cnt      = 0;
    bit chk_on     = 1'b0;

    typedef struct {
        bit     pc, ifid, flush, bubble, exmem, memwb;
        cause_e cause;
    } exp_t;

    function automatic bit model_busy();
        return (cyc > last_start) && (cyc <= last_start + int'(LAT));
    endfunction

    function automatic exp_t set_exp(bit pc, bit ifd, bit fl, bit bub, bit ex, bit wb, cause_e c);
        exp_t e;
        e.pc = pc; e.ifid = ifd; e.flush = fl; e.bubble = bub;
        e.exmem = ex; e.memwb = wb; e.cause = c;
        return e;
    endfunction

    function automatic exp_t model_out();
        bit lu;
        lu = idex_memread && (idex_rt != 0) &&
             ((idex_rt == ifid_rs) || (id_uses_rt && (idex_rt == ifid_rt)));
        if (reset)                          return set_exp(0, 0, 1, 1, 0, 0, CauseNone);
        if (dmem_req && !dmem_ready)        return set_exp(0, 0, 0, 0, 0, 0, CauseMem);
        if (lu)                             return set_exp(0, 0, 0, 1, 1, 1, CauseLoadUse);
        if (id_mdu_read && model_busy())    return set_exp(0, 0, 0, 1, 1, 1, CauseMdu);
        if (branch_taken)                   return set_exp(1, 1, 1, 0, 1, 1, CauseBranch);
        if (!imem_ready)                    return set_exp(0, 1, 1, 0, 1, 1, CauseFetch);
        return set_exp(1, 1, 0, 0, 1, 1, CauseNone);
    endfunction

    // Model update: inputs still hold this cycle's values at the rising edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        e = model_out();
        if (reset) begin
            last_start = -1000;
            m_wait     = 1'b0;
            m_cnt      = 0;
        end else begin
            if (mdu_start && e.exmem) last_start = cyc;
            if (dmem_req && !dmem_ready) m_wait = 1'b1;
            else if (dmem_ready)         m_wait = 1'b0;
            if (!e.pc && m_cnt < CntMax) m_cnt++;
        end
        cyc++;
    end

    // Per-cycle compare against the model, on the falling edge.
    initial forever begin
        exp_t   e;
        state_e want_st;
        @(negedge clk);
        if (chk_on) begin
            e       = model_out();
            want_st = m_wait ? StMemWait : StRun;
            check("pc_en", pc_en, e.pc);
            check("ifid_en", ifid_en, e.ifid);
            check("ifid_flush", ifid_flush, e.flush);
            check("idex_bubble", idex_bubble, e.bubble);
            check("exmem_en", exmem_en, e.exmem);
            check("memwb_en", memwb_en, e.memwb);
            check("mdu_busy", mdu_busy, model_busy());
            check("stall_cnt", stall_cnt, PerfEn ? m_cnt : 0);
            check("fsm_state", dut.state_q, want_st);
            check("cause", dut.cause, e.cause);
        end
    end

    task automatic idle_inputs();
        reset = 0; ifid_rs = 5'd1; ifid_rt = 5'd2; id_uses_rt = 0; idex_rt = 5'd0;
        idex_memread = 0; branch_taken = 0; imem_ready = 1; dmem_req = 0;
        dmem_ready = 1; mdu_start = 0; id_mdu_read = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        next();
        chk_on = 1;
        @(negedge clk);
        check("rst_pc_en", pc_en, 0);
        check("rst_ifid_flush", ifid_flush, 1);
        check("rst_idex_bubble", idex_bubble, 1);
        check("rst_memwb_en", memwb_en, 0);

        next(); idle_inputs();
        @(negedge clk);
        check("idle_pc_en", pc_en, 1);
        check("post_rst_stall_cnt", stall_cnt, 0);

        // Load-use through rs, release, r0 exemption, rt path
        next(); set_lu();
        @(negedge clk);
        check("lu_pc_en", pc_en, 0);
        check("lu_ifid_en", ifid_en, 0);
        check("lu_bubble", idex_bubble, 1);
        check("lu_exmem_en", exmem_en, 1);
        next(); idle_inputs();
        @(negedge clk);
        check("lu_release_pc_en", pc_en, 1);
        check("lu_release_bubble", idex_bubble, 0);
        next(); idex_memread = 1; idex_rt = 5'd0; ifid_rs = 5'd0;
        @(negedge clk);
        check("lu_r0_pc_en", pc_en, 1);
        next(); idle_inputs(); idex_memread = 1; idex_rt = 5'd9; ifid_rt = 5'd9; id_uses_rt = 1;
        @(negedge clk);
        check("lu_rt_bubble", idex_bubble, 1);
        next(); id_uses_rt = 0;
        @(negedge clk);
        check("lu_rt_unused_bubble", idex_bubble, 0);

        // MDU issue, consumer arrives two cycles later
        next(); idle_inputs(); mdu_start = 1;
        next(); mdu_start = 0;
        next(); id_mdu_read = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next();
            @(negedge clk);
            check("mdu_stall_pc_en", pc_en, 0);
        end
        next();
        @(negedge clk);
        check("mdu_release_pc_en", pc_en, 1);
        check("mdu_release_busy", mdu_busy, 0);

        // Back-to-back issue reloads the latency
        next(); id_mdu_read = 0; mdu_start = 1;
        next();
        next(); mdu_start = 0; id_mdu_read = 1;
        repeat (5) next();
        idle_inputs();

        // Issue during a memory freeze is dropped
        next(); mdu_start = 1; dmem_req = 1; dmem_ready = 0;
        @(negedge clk);
        check("frz_exmem_en", exmem_en, 0);
        next(); mdu_start = 0; dmem_ready = 1; id_mdu_read = 1;
        @(negedge clk);
        check("frz_start_dropped", mdu_busy, 0);

        // MDU count keeps running through a freeze
        next(); idle_inputs(); mdu_start = 1;
        next(); mdu_start = 0; dmem_req = 1; dmem_ready = 0;
        next(); next();
        next(); dmem_ready = 1; id_mdu_read = 1;
        @(negedge clk);
        check("mdu_frz_last_stall", idex_bubble, 1);
        next();
        @(negedge clk);
        check("mdu_frz_release", pc_en, 1);

        // Memory wait of three cycles, load-use inside it
        next(); idle_inputs(); dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next();
            if (i == 1) set_lu();
            @(negedge clk);
            check("mw_pc_en", pc_en, 0);
            check("mw_memwb_en", memwb_en, 0);
            check("mw_bubble", idex_bubble, 0);
            if (i > 0) check("mw_fsm", dut.state_q, StMemWait);
        end
        next(); idle_inputs(); dmem_req = 1; dmem_ready = 1;
        @(negedge clk);
        check("mw_done_memwb_en", memwb_en, 1);
        next(); idle_inputs();
        @(negedge clk);
        check("mw_back_run", dut.state_q, StRun);

        // Branch beats fetch wait; ignored under load-use
        next(); branch_taken = 1; imem_ready = 0;
        @(negedge clk);
        check("br_pc_en", pc_en, 1);
        check("br_flush", ifid_flush, 1);
        next(); imem_ready = 1; set_lu();
        @(negedge clk);
        check("br_lu_flush", ifid_flush, 0);
        check("br_lu_pc_en", pc_en, 0);
        next(); idle_inputs(); imem_ready = 0;
        @(negedge clk);
        check("fw_pc_en", pc_en, 0);
        check("fw_flush", ifid_flush, 1);
        check("fw_exmem_en", exmem_en, 1);

        // Reset in the middle of a memory wait with the MDU busy
        next(); idle_inputs(); mdu_start = 1;
        next(); mdu_start = 0; dmem_req = 1; dmem_ready = 0;
        next(); reset = 1;
        @(negedge clk);
        check("pre_rst_fsm", dut.state_q, StMemWait);
        check("pre_rst_busy", mdu_busy, 1);
        next(); idle_inputs();
        @(negedge clk);
        check("rst_mid_fsm", dut.state_q, StRun);
        check("rst_mid_busy", mdu_busy, 0);
        check("rst_mid_stall_cnt", stall_cnt, 0);
        check("rst_mid_pc_en", pc_en, 1);

        // Stall counter: five stalls, then saturation
        next(); set_lu();
        repeat (4) next();
        next(); idle_inputs();
        @(negedge clk);
        check("cnt_five", stall_cnt, PerfEn ? 5 : 0);
        next(); set_lu();
        repeat (19) next();
        next(); idle_inputs();
        @(negedge clk);
        check("cnt_saturated", stall_cnt, PerfEn ? CntMax : 0);

        repeat (2) next();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
